sample_feeder: RTL and testbench
================================

Name: sample_feeder

Overview:
- Training-sample source that sits directly upstream of the neuron.
- Buffers a loaded data set of (x1, x2, t) samples and serves one sample per neuron request using the requestFlag/dataReady handshake.
- Wraps the read pointer at the end of the set to serve repeated epochs, and stops when the neuron asserts done.
- Also drives the neuron's sample-count input.

Parameters:
- DEPTH, 512, maximum number of stored samples.
- ADDR_W, 9, pointer width; must satisfy 2**ADDR_W >= DEPTH.
- X_W, 7, signed width of x1/x2.
- T_W, 2, signed width of target t.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- load_en  in  1  write one sample this cycle.
- load_x1  in  X_W  sample x1, signed.
- load_x2  in  X_W  sample x2, signed.
- load_t  in  T_W  sample target, signed.
- start  in  1  level; begin streaming.
- clear  in  1  synchronous pulse; empty the buffer and return to IDLE.
- requestFlag  in  1  neuron requests the next sample.
- done  in  1  neuron training finished.
- x1Input  out  X_W  current sample x1.
- x2Input  out  X_W  current sample x2.
- tInput  out  T_W  current sample t.
- dataReady  out  1  one-cycle strobe; the x/t outputs are valid.
- nInput  out  32  stored sample count, zero-extended.
- epoch_count  out  16  completed passes over the set; saturates at 16'hFFFF.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- busy  out  1  state is WAIT or GAP.

Behaviour:
- Reset (async, rst=1): all outputs 0, count=0, rd_ptr=0, wr_ptr=0, state=IDLE. Memory contents are not cleared; they are unreachable because count=0.
- Storage: register array, synchronous write, combinational read.
- States:
  - IDLE:
    - load_en=1 and !full: mem[wr_ptr] <= sample, wr_ptr++, count++.
    - load_en=1 and full: write dropped, overflow <= 1.
    - start=1 and count>0: go to WAIT with rd_ptr=0, epoch_count=0.
    - start=1 and count==0: ignored, remain in IDLE.
    - When load_en and start are both high in the same cycle, the write is performed and the start transition uses the pre-write count.
  - WAIT:
    - done=1: go to DONE.
    - Else requestFlag=1: at this edge, x1Input/x2Input/tInput <= mem[rd_ptr] and dataReady <= 1; then go to GAP.
    - Pointer advance on an issue: if rd_ptr==count-1, rd_ptr <= 0 and epoch_count++ (saturating); otherwise rd_ptr++.
  - GAP:
    - dataReady <= 0 unconditionally.
    - done=1: go to DONE; otherwise go to WAIT.
    - Guarantees at most one issue per two cycles, so a requestFlag held high across the strobe cannot double-issue.
  - DONE:
    - dataReady=0; outputs hold their last values.
    - Stays until clear.
- clear:
  - Honoured in any state.
  - Next state IDLE; count, wr_ptr, rd_ptr, epoch_count, overflow, dataReady all <= 0.
  - x/t outputs hold their last values.
  - clear overrides load_en, start and requestFlag in the same cycle.
- load_en outside IDLE: ignored, and does not set overflow.
- Timing: latency from requestFlag sampled high in WAIT to dataReady high is one edge. dataReady is high for exactly one cycle. x/t outputs stay stable until the next issue.
- Simultaneous done and requestFlag in WAIT: done wins; no issue, no pointer move.
- Wrap: with count==1, every issue serves sample 0 and increments epoch_count.
- nInput: {(32-ADDR_W-1)'b0, count} continuously; count needs ADDR_W+1 bits to represent DEPTH.
- full: combinational from count.
- busy: high in WAIT and GAP only.
- Reset mid-stream: immediate return to IDLE with count=0; the set must be reloaded.

Test Plan:
- Load 3 samples (x1,x2,t) = (5,-3,1), (-7,2,-1), (0,63,1); check nInput=3. Assert start and hold requestFlag=1 continuously. Required: dataReady pulses every 2nd cycle with samples 0,1,2,0,1; epoch_count=1 after the 3rd issue; x/t outputs carry the correct sign-extended values.
- In WAIT, raise requestFlag and done in the same cycle -> no dataReady, state DONE, rd_ptr unchanged; requestFlag afterwards -> no further strobes.
- Load DEPTH samples plus 1 more -> full=1, overflow=1, nInput=512, and the last write is dropped (the issue at index 511 returns the 512th sample).
- start with count=0 -> busy stays 0, no dataReady. Then load 1 sample and start, and issue 3 requests -> sample 0 returned three times, epoch_count=3.
- Assert rst asynchronously (mid-cycle) while in GAP -> dataReady, busy and nInput go to 0 immediately, without a clock edge. After release, loading and streaming restart cleanly.
- Assert clear during WAIT together with load_en and requestFlag -> IDLE, count=0, no dataReady, no write, overflow=0.

Source files
------------

// File: rtl/sample_feeder.sv
// sample_feeder: buffers a loaded set of (x1, x2, t) training samples and
// serves them one at a time to the neuron, wrapping at the end of the set
// to run repeated epochs until the neuron reports done.
//
// Handshake: the neuron raises requestFlag (it may hold it high). A request
// sampled high in WAIT causes the sample at rd_ptr to be registered onto
// x1Input/x2Input/tInput with a one-cycle dataReady strobe at the same edge.
// The mandatory GAP cycle that follows means a request held high cannot be
// served twice by one strobe. The outputs hold until the next issue.
module sample_feeder #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int X_W    = 7,
    parameter int T_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [X_W-1:0]    load_x1,
    input  logic [X_W-1:0]    load_x2,
    input  logic [T_W-1:0]    load_t,
    input  logic              start,
    input  logic              clear,
    input  logic              requestFlag,
    input  logic              done,
    output logic [X_W-1:0]    x1Input,
    output logic [X_W-1:0]    x2Input,
    output logic [T_W-1:0]    tInput,
    output logic              dataReady,
    output logic [31:0]       nInput,
    output logic [15:0]       epoch_count,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int SW = 2 * X_W + T_W;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [SW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_en;
    logic              wr_drop;
    logic              go;
    logic              issue;
    logic              last;
    logic [SW-1:0]     rd_word;

    assign full      = (count == CNT_MAX);
    assign nInput    = {{(32 - ADDR_W - 1){1'b0}}, count};
    assign busy      = (state == S_WAIT) || (state == S_GAP);
    assign state_dbg = state;
    assign rd_word   = mem[rd_ptr];
    assign last      = ({1'b0, rd_ptr} == (count - CNT_ONE));

    // Decode the per-cycle actions; clear suppresses every other action.
    always_comb begin
        wr_en   = 1'b0;
        wr_drop = 1'b0;
        go      = 1'b0;
        issue   = 1'b0;
        if (!clear) begin
            if (state == S_IDLE) begin
                wr_en   = load_en && !full;
                wr_drop = load_en && full;
                go      = start && (count != '0);
            end
            if (state == S_WAIT) begin
                issue = requestFlag && !done;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; done has priority over a request in WAIT.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (go) state_nx = S_WAIT;
                S_WAIT: begin
                    if (done) state_nx = S_DONE;
                    else if (requestFlag) state_nx = S_GAP;
                end
                S_GAP:  state_nx = done ? S_DONE : S_WAIT;
                S_DONE: state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Sample storage; never reset, stale words are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {load_x1, load_x2, load_t};
        end
    end

    // Pointers, counters, flags and the registered sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            epoch_count <= '0;
            overflow    <= 1'b0;
            dataReady   <= 1'b0;
            x1Input     <= '0;
            x2Input     <= '0;
            tInput      <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            epoch_count <= '0;
            overflow    <= 1'b0;
            dataReady   <= 1'b0;
        end else begin
            dataReady <= issue;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (go) begin
                rd_ptr      <= '0;
                epoch_count <= '0;
            end
            if (issue) begin
                {x1Input, x2Input, tInput} <= rd_word;
                if (last) begin
                    rd_ptr <= '0;
                    if (epoch_count != 16'hFFFF) begin
                        epoch_count <= epoch_count + 16'd1;
                    end
                end else begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: a scoreboard queue holds the samples expected on
// each dataReady strobe; scenario tasks drive the handshake and check flags.
module tb_sample_feeder;

    localparam int DEPTH = 512;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [6:0]  load_x1 = '0;
    logic [6:0]  load_x2 = '0;
    logic [1:0]  load_t = '0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        requestFlag = 1'b0;
    logic        done = 1'b0;
    logic [6:0]  x1Input;
    logic [6:0]  x2Input;
    logic [1:0]  tInput;
    logic        dataReady;
    logic [31:0] nInput;
    logic [15:0] epoch_count;
    logic        full;
    logic        overflow;
    logic        busy;
    logic [1:0]  state_dbg;

    logic [15:0] exp_q[$];
    logic [15:0] model [DEPTH];
    int          vectors = 0;
    int          miscompares = 0;
    int          strobes = 0;
    logic        prev_dr = 1'b0;

    sample_feeder dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_x1(load_x1),
        .load_x2(load_x2), .load_t(load_t), .start(start), .clear(clear),
        .requestFlag(requestFlag), .done(done), .x1Input(x1Input),
        .x2Input(x2Input), .tInput(tInput), .dataReady(dataReady),
        .nInput(nInput), .epoch_count(epoch_count), .full(full),
        .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: each strobe pops one expected sample; strobes must be one cycle wide
    always @(negedge clk) begin
        if (dataReady) begin
            strobes++;
            vectors++;
            if (prev_dr) begin
                miscompares++;
                $display("FAIL dr_width: dataReady high two cycles running at %0t", $time);
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got %h, nothing expected", {x1Input, x2Input, tInput});
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({x1Input, x2Input, tInput} !== e) begin
                    miscompares++;
                    $display("FAIL sample: got %h exp %h", {x1Input, x2Input, tInput}, e);
                end
            end
        end
        prev_dr = dataReady;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
        #1;
    endtask

    task automatic load_sample(input logic [6:0] a, input logic [6:0] b, input logic [1:0] c);
        load_en = 1'b1;
        load_x1 = a;
        load_x2 = b;
        load_t  = c;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (strobes < target && n < budget) begin
            sample_pt();
            n++;
        end
        vectors++;
        if (strobes < target) begin
            miscompares++;
            $display("FAIL strobe_timeout: got %0d strobes exp %0d", strobes, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        sample_pt();
        vectors++;
        if ({dataReady, busy, full, overflow, nInput, epoch_count, x1Input, x2Input, tInput, state_dbg} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got dr=%b busy=%b full=%b ovf=%b n=%0d ep=%0d st=%0d",
                     dataReady, busy, full, overflow, nInput, epoch_count, state_dbg);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic [15:0] s [3];
        int base;
        s[0] = {7'sd5, -7'sd3, 2'sd1};
        s[1] = {-7'sd7, 7'sd2, -2'sd1};
        s[2] = {7'sd0, 7'sd63, 2'sd1};
        for (int i = 0; i < 3; i++) load_sample(s[i][15:9], s[i][8:2], s[i][1:0]);
        sample_pt();
        vectors++;
        if (nInput !== 32'd3) begin
            miscompares++;
            $display("FAIL stream_count: got %0d exp 3", nInput);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back(s[i % 3]);
        base = strobes;
        requestFlag = 1'b1;
        pulse_start();
        sample_pt();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_busy: got %b exp 1", busy);
        end
        wait_strobes(base + 3, 20);
        vectors++;
        if (epoch_count !== 16'd1) begin
            miscompares++;
            $display("FAIL stream_epoch3: got %0d exp 1", epoch_count);
        end
        vectors++;
        if ($signed(x2Input) !== 7'sd63 || $signed(tInput) !== 2'sd1) begin
            miscompares++;
            $display("FAIL stream_third: got x2=%0d t=%0d exp 63 1", $signed(x2Input), $signed(tInput));
        end
        wait_strobes(base + 5, 20);
        requestFlag = 1'b0;
        vectors++;
        if (epoch_count !== 16'd1) begin
            miscompares++;
            $display("FAIL stream_epoch5: got %0d exp 1", epoch_count);
        end
    endtask

    task automatic test_done_priority();
        int base;
        tick();
        base = strobes;
        done = 1'b1;
        requestFlag = 1'b1;
        tick();
        done = 1'b0;
        sample_pt();
        vectors++;
        if (state_dbg !== ST_DONE || dataReady !== 1'b0) begin
            miscompares++;
            $display("FAIL done_wins: got st=%0d dr=%b exp st=3 dr=0", state_dbg, dataReady);
        end
        repeat (6) tick();
        sample_pt();
        vectors++;
        if (strobes !== base || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_hold: got strobes=%0d busy=%b exp %0d 0", strobes, busy, base);
        end
        requestFlag = 1'b0;
        pulse_clear();
        sample_pt();
        vectors++;
        if (state_dbg !== ST_IDLE || nInput !== 32'd0) begin
            miscompares++;
            $display("FAIL done_clear: got st=%0d n=%0d exp 0 0", state_dbg, nInput);
        end
    endtask

    task automatic test_full_overflow();
        int base;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'($urandom_range(0, 65535));
            load_sample(model[i][15:9], model[i][8:2], model[i][1:0]);
        end
        sample_pt();
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b0 || nInput !== 32'd512) begin
            miscompares++;
            $display("FAIL full_flag: got full=%b ovf=%b n=%0d exp 1 0 512", full, overflow, nInput);
        end
        load_sample(~model[DEPTH-1][15:9], ~model[DEPTH-1][8:2], ~model[DEPTH-1][1:0]);
        sample_pt();
        vectors++;
        if (overflow !== 1'b1 || nInput !== 32'd512) begin
            miscompares++;
            $display("FAIL overflow: got ovf=%b n=%0d exp 1 512", overflow, nInput);
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
        base = strobes;
        requestFlag = 1'b1;
        pulse_start();
        wait_strobes(base + DEPTH, 1200);
        requestFlag = 1'b0;
        vectors++;
        if (epoch_count !== 16'd1) begin
            miscompares++;
            $display("FAIL full_epoch: got %0d exp 1", epoch_count);
        end
    endtask

    task automatic test_clear_in_wait();
        int base;
        tick();
        sample_pt();
        vectors++;
        if (state_dbg !== ST_WAIT) begin
            miscompares++;
            $display("FAIL clear_pre: got st=%0d exp 1", state_dbg);
        end
        base = strobes;
        clear = 1'b1;
        load_en = 1'b1;
        requestFlag = 1'b1;
        load_x1 = 7'h11;
        tick();
        clear = 1'b0;
        load_en = 1'b0;
        requestFlag = 1'b0;
        sample_pt();
        vectors++;
        if (state_dbg !== ST_IDLE || nInput !== 32'd0 || overflow !== 1'b0 ||
            dataReady !== 1'b0 || epoch_count !== 16'd0 || strobes !== base) begin
            miscompares++;
            $display("FAIL clear_wait: got st=%0d n=%0d ovf=%b dr=%b ep=%0d", state_dbg, nInput,
                     overflow, dataReady, epoch_count);
        end
    endtask

    task automatic test_start_empty();
        int base;
        logic [15:0] s;
        base = strobes;
        start = 1'b1;
        requestFlag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_pt();
            vectors++;
            if (busy !== 1'b0 || strobes !== base) begin
                miscompares++;
                $display("FAIL empty_start: got busy=%b strobes=%0d exp 0 %0d", busy, strobes, base);
            end
        end
        tick();
        start = 1'b0;
        requestFlag = 1'b0;
        s = 16'($urandom_range(0, 65535));
        load_sample(s[15:9], s[8:2], s[1:0]);
        for (int i = 0; i < 3; i++) exp_q.push_back(s);
        requestFlag = 1'b1;
        pulse_start();
        wait_strobes(base + 3, 20);
        requestFlag = 1'b0;
        vectors++;
        if (epoch_count !== 16'd3) begin
            miscompares++;
            $display("FAIL single_epoch: got %0d exp 3", epoch_count);
        end
        pulse_clear();
    endtask

    task automatic test_async_reset();
        int base;
        logic [15:0] s [2];
        for (int i = 0; i < 2; i++) begin
            s[i] = 16'($urandom_range(0, 65535));
            load_sample(s[i][15:9], s[i][8:2], s[i][1:0]);
        end
        exp_q.push_back(s[0]);
        base = strobes;
        requestFlag = 1'b1;
        pulse_start();
        wait_strobes(base + 1, 20);
        requestFlag = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (dataReady !== 1'b0 || busy !== 1'b0 || nInput !== 32'd0 || state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL async_rst: got dr=%b busy=%b n=%0d st=%0d exp all 0", dataReady, busy,
                     nInput, state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            s[i] = 16'($urandom_range(0, 65535));
            load_sample(s[i][15:9], s[i][8:2], s[i][1:0]);
            exp_q.push_back(s[i]);
        end
        base = strobes;
        requestFlag = 1'b1;
        pulse_start();
        wait_strobes(base + 2, 20);
        requestFlag = 1'b0;
        vectors++;
        if (epoch_count !== 16'd1) begin
            miscompares++;
            $display("FAIL restart_epoch: got %0d exp 1", epoch_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_done_priority();
        test_full_overflow();
        test_clear_in_wait();
        test_start_empty();
        test_async_reset();
        repeat (4) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d samples pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
